icache_refill_unit: RTL and testbench



---
 rtl/icache_refill_unit.sv | 182 ++++++++++++++++++
 tb/tb_icache_refill_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_unit.sv
// -----------------------------------------------------------------------------
// icache_refill_unit
//
// Miss-refill engine between the instruction cache and the memory bus. A
// one-cycle line-address request from the cache starts a single burst read of
// block_size words. The returned beats are assembled into one cache line, and
// the line is handed back with a single-cycle valid pulse.
//
// Ports
//   CLK, RST            clock; synchronous active-high reset
//   FLUSH               drop the result of the refill in flight (the burst still
//                       runs to completion)
//   ADDR_TO_L2_VALID    one-cycle request pulse from the cache
//   ADDR_TO_L2          line address of the miss
//   DATA_FROM_L2        assembled line; held until the next refill overwrites it
//   DATA_FROM_L2_VALID  one-cycle line-valid pulse
//   MEM_AR*             burst read address channel (ARLEN is constant)
//   MEM_R*              burst read data channel
//   BUSY                refill in progress
//   ERR                 sticky burst-length error, cleared only by RST
// -----------------------------------------------------------------------------
module icache_refill_unit #(
  parameter int data_width    = 32,
  parameter int address_width = 32,
  parameter int block_size    = 32
) (
  input  logic                                                          CLK,
  input  logic                                                          RST,
  input  logic                                                          FLUSH,
  input  logic                                                          ADDR_TO_L2_VALID,
  input  logic [address_width-$clog2(data_width*block_size/8)-1:0]      ADDR_TO_L2,
  output logic [block_size*data_width-1:0]                              DATA_FROM_L2,
  output logic                                                          DATA_FROM_L2_VALID,
  output logic [address_width-1:0]                                      MEM_ARADDR,
  output logic [7:0]                                                    MEM_ARLEN,
  output logic                                                          MEM_ARVALID,
  input  logic                                                          MEM_ARREADY,
  input  logic [data_width-1:0]                                         MEM_RDATA,
  input  logic                                                          MEM_RVALID,
  input  logic                                                          MEM_RLAST,
  output logic                                                          MEM_RREADY,
  output logic                                                          BUSY,
  output logic                                                          ERR
);

  localparam int offset_width = $clog2(data_width*block_size/8);
  localparam int line_width   = block_size*data_width;
  localparam int cnt_width    = (block_size > 1) ? $clog2(block_size) : 1;

  localparam logic [cnt_width-1:0] last_cnt  = cnt_width'(block_size-1);
  localparam logic [7:0]           arlen_val = 8'(block_size-1);

  typedef enum logic [1:0] {IDLE, REQ, RECV, RESP} state_t;

  state_t                     state_reg, state_next;
  logic [cnt_width-1:0]       cnt_reg;
  logic                       flush_pend_reg;
  logic [address_width-1:0]   araddr_reg;
  logic                       err_reg;
  logic [data_width-1:0]      word_reg [block_size];

  logic beat_accept;
  logic last_beat;

  assign beat_accept = (state_reg == RECV) && MEM_RVALID;
  // The beat counter, not RLAST, decides where the burst ends.
  assign last_beat   = (cnt_reg == last_cnt);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    MEM_ARVALID        = 1'b0;
    MEM_RREADY         = 1'b0;
    BUSY               = 1'b1;
    DATA_FROM_L2_VALID = 1'b0;
    case (state_reg)
      IDLE: begin
        BUSY = 1'b0;
        if (ADDR_TO_L2_VALID) begin
          state_next = REQ;
        end
      end
      REQ: begin
        MEM_ARVALID = 1'b1;
        if (MEM_ARREADY) begin
          state_next = RECV;
        end
      end
      RECV: begin
        MEM_RREADY = 1'b1;
        if (beat_accept && last_beat) begin
          state_next = RESP;
        end
      end
      RESP: begin
        // A flush seen during the burst, or in this very cycle, drops the pulse.
        DATA_FROM_L2_VALID = !flush_pend_reg && !FLUSH;
        state_next         = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control datapath: address latch, beat counter, flush and error flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_reg        <= '0;
      flush_pend_reg <= 1'b0;
      araddr_reg     <= '0;
      err_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ADDR_TO_L2_VALID) begin
            araddr_reg <= {ADDR_TO_L2, {offset_width{1'b0}}};
          end
        end
        REQ: begin
          if (FLUSH) begin
            flush_pend_reg <= 1'b1;
          end
          if (MEM_ARREADY) begin
            cnt_reg <= '0;
          end
        end
        RECV: begin
          if (FLUSH) begin
            flush_pend_reg <= 1'b1;
          end
          if (MEM_RVALID) begin
            cnt_reg <= cnt_reg + cnt_width'(1);
            // RLAST must coincide exactly with the counter's final beat.
            if (last_beat != MEM_RLAST) begin
              err_reg <= 1'b1;
            end
          end
        end
        RESP: begin
          flush_pend_reg <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Line assembly: beat k lands in word k
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < block_size; i++) begin
        word_reg[i] <= '0;
      end
    end else if (beat_accept) begin
      word_reg[cnt_reg] <= MEM_RDATA;
    end
  end

  for (genvar gi = 0; gi < block_size; gi++) begin : g_line
    assign DATA_FROM_L2[gi*data_width +: data_width] = word_reg[gi];
  end

  assign MEM_ARADDR = araddr_reg;
  assign MEM_ARLEN  = arlen_val;
  assign ERR        = err_reg;

endmodule

// File: tb/tb_icache_refill_unit.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_unit
//
// Table-driven bench for icache_refill_unit at default parameters. Each table
// record describes one refill (bus stalls, beat gaps, flush/extra-request
// timing, RLAST placement) together with its hand-computed expectations. A
// small memory responder drives the burst; a hand-written sequence covers
// reset in the middle of a burst.
// -----------------------------------------------------------------------------
module tb_icache_refill_unit;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BS = 32;
  localparam int OW = 7;
  localparam int LW = BS*DW;
  localparam int LA = AW-OW;

  logic          CLK = 1'b0;
  logic          RST;
  logic          FLUSH;
  logic          ADDR_TO_L2_VALID;
  logic [LA-1:0] ADDR_TO_L2;
  logic [LW-1:0] DATA_FROM_L2;
  logic          DATA_FROM_L2_VALID;
  logic [AW-1:0] MEM_ARADDR;
  logic [7:0]    MEM_ARLEN;
  logic          MEM_ARVALID;
  logic          MEM_ARREADY;
  logic [DW-1:0] MEM_RDATA;
  logic          MEM_RVALID;
  logic          MEM_RLAST;
  logic          MEM_RREADY;
  logic          BUSY;
  logic          ERR;

  always #5 CLK = ~CLK;

  icache_refill_unit #(
    .data_width    (DW),
    .address_width (AW),
    .block_size    (BS)
  ) dut (
    .CLK                (CLK),
    .RST                (RST),
    .FLUSH              (FLUSH),
    .ADDR_TO_L2_VALID   (ADDR_TO_L2_VALID),
    .ADDR_TO_L2         (ADDR_TO_L2),
    .DATA_FROM_L2       (DATA_FROM_L2),
    .DATA_FROM_L2_VALID (DATA_FROM_L2_VALID),
    .MEM_ARADDR         (MEM_ARADDR),
    .MEM_ARLEN          (MEM_ARLEN),
    .MEM_ARVALID        (MEM_ARVALID),
    .MEM_ARREADY        (MEM_ARREADY),
    .MEM_RDATA          (MEM_RDATA),
    .MEM_RVALID         (MEM_RVALID),
    .MEM_RLAST          (MEM_RLAST),
    .MEM_RREADY         (MEM_RREADY),
    .BUSY               (BUSY),
    .ERR                (ERR)
  );

  typedef struct {
    bit            do_reset;
    logic [LA-1:0] addr;
    int            stall;            // cycles ARREADY is held low
    bit            gap;              // offer beats only every other cycle
    int            flush_cycle;      // cycle FLUSH is high (-1 none)
    int            rlast_beat;       // extra RLAST on this beat index (-1 none)
    bit            rlast_final;      // RLAST on beat 31
    int            extra_req_cycle;  // cycle of a second request pulse (-1 none)
    logic [31:0]   base;             // beat k carries base+k
    logic [31:0]   exp_araddr;
    int            exp_arv_cycles;
    bit            exp_pulse;
    int            exp_pulse_cycle;
    bit            exp_err;
  } vec_t;

  vec_t vec [12];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    FLUSH            = 1'b0;
    ADDR_TO_L2_VALID = 1'b0;
    ADDR_TO_L2       = '0;
    MEM_ARREADY      = 1'b0;
    MEM_RDATA        = '0;
    MEM_RVALID       = 1'b0;
    MEM_RLAST        = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " busy"},    32'(BUSY), 32'd0);
    chk({tag, " arvalid"}, 32'(MEM_ARVALID), 32'd0);
    chk({tag, " rready"},  32'(MEM_RREADY), 32'd0);
    chk({tag, " valid"},   32'(DATA_FROM_L2_VALID), 32'd0);
    chk({tag, " err"},     32'(ERR), 32'd0);
    chk({tag, " araddr"},  MEM_ARADDR, 32'd0);
    chk({tag, " arlen"},   32'(MEM_ARLEN), 32'd31);
    chk({tag, " line_or"}, 32'(|DATA_FROM_L2), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge CLK); #1;
    idle_inputs();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check_cleared(tag);
  endtask

  // One refill: cycle 0 is the request cycle. Inputs change 1 time unit after
  // the rising edge; outputs are sampled on the falling edge.
  task automatic run_vec(input int idx, input vec_t v);
    int  beats     = 0;
    bit  ar_done   = 0;
    bit  phase     = 0;
    bit  offer;
    int  arv_cyc   = 0;
    int  addr_bad  = 0;
    int  busy_bad  = 0;
    int  pulses    = 0;
    int  pulse_c   = -1;
    int  last_c    = -1;
    int  line_bad  = 0;
    int  first_bad = -1;
    bit  timed_out = 0;
    string t;
    t = $sformatf("v%0d", idx);
    if (v.do_reset) begin
      do_reset({t, " reset"});
    end
    for (int c = 0; ; c++) begin
      @(posedge CLK); #1;
      ADDR_TO_L2_VALID = (c == 0) || (c == v.extra_req_cycle);
      ADDR_TO_L2       = (c == 0) ? v.addr : (v.addr ^ 25'h155);
      FLUSH            = (c == v.flush_cycle);
      MEM_ARREADY      = (c >= 1 + v.stall);
      offer            = ar_done && (beats < BS) && (!v.gap || phase);
      MEM_RVALID       = offer;
      MEM_RDATA        = offer ? (v.base + 32'(beats)) : (32'hBAD0_0000 + 32'(c));
      MEM_RLAST        = offer && ((beats == v.rlast_beat) || ((beats == BS-1) && v.rlast_final));
      @(negedge CLK);
      if (c == 0) begin
        chk({t, " idle_at_request"}, 32'(BUSY), 32'd0);
        chk({t, " arlen"}, 32'(MEM_ARLEN), 32'd31);
      end else if (!BUSY) begin
        busy_bad++;
      end
      if (MEM_ARVALID) begin
        arv_cyc++;
        if (MEM_ARADDR !== v.exp_araddr) addr_bad++;
      end
      if (ar_done) phase = !phase;
      if (MEM_ARVALID && MEM_ARREADY) begin
        ar_done = 1;
        phase   = 1;
      end
      if (MEM_RVALID && MEM_RREADY) begin
        beats++;
        if (beats == BS) last_c = c;
      end
      if (DATA_FROM_L2_VALID) begin
        pulses++;
        pulse_c = c;
      end
      if ((beats == BS) && (c == last_c + 1)) break;
      if (c > 200) begin
        timed_out = 1;
        break;
      end
    end
    if (timed_out) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d beats, expected %0d within 200 cycles", t, beats, BS);
    end
    for (int k = 0; k < BS; k++) begin
      if (DATA_FROM_L2[k*DW +: DW] !== v.base + 32'(k)) begin
        line_bad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    chk({t, " arvalid_cycles"}, 32'(arv_cyc), 32'(v.exp_arv_cycles));
    chk({t, " araddr_unstable"}, 32'(addr_bad), 32'd0);
    chk({t, " araddr_hold"}, MEM_ARADDR, v.exp_araddr);
    chk({t, " busy_drop"}, 32'(busy_bad), 32'd0);
    chk({t, " pulses"}, 32'(pulses), 32'(v.exp_pulse));
    if (v.exp_pulse) chk({t, " pulse_cycle"}, 32'(pulse_c), 32'(v.exp_pulse_cycle));
    chk({t, " line_bad_words"}, 32'(line_bad), 32'd0);
    chk({t, " err"}, 32'(ERR), 32'(v.exp_err));
    $display("%s: addr=0x%0h araddr=0x%0h arvalid_cycles=%0d pulses=%0d pulse_cycle=%0d bad_words=%0d first_bad=%0d err=%0b",
             t, v.addr, MEM_ARADDR, arv_cyc, pulses, pulse_c, line_bad, first_bad, ERR);
  endtask

  // Reset asserted after five beats while the bus keeps presenting data.
  task automatic reset_mid_burst();
    int late_bad = 0;
    for (int c = 0; c <= 12; c++) begin
      @(posedge CLK); #1;
      ADDR_TO_L2_VALID = (c == 0);
      ADDR_TO_L2       = 25'h77;
      MEM_ARREADY      = 1'b1;
      MEM_RVALID       = (c >= 2);
      MEM_RDATA        = 32'h9900 + 32'(c);
      MEM_RLAST        = 1'b0;
      RST              = (c == 7);
      @(negedge CLK);
      if (c == 6) chk("rstmid busy_before", 32'(BUSY), 32'd1);
      if (c == 8) check_cleared("rstmid after");
      if (c >= 9 && (MEM_RREADY || BUSY || DATA_FROM_L2_VALID || MEM_ARVALID)) late_bad++;
    end
    chk("rstmid late_beats_seen", 32'(late_bad), 32'd0);
    chk("rstmid line_or", 32'(|DATA_FROM_L2), 32'd0);
    $display("rstmid: reset after beat 5, late activity cycles=%0d", late_bad);
    @(posedge CLK); #1;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    idle_inputs();
    repeat (2) @(posedge CLK);

    //           rst   addr           stall gap flush rlastb fin extra base           araddr         arv pls pcyc err
    vec[0]  = '{1'b1, 25'h0000200,   0,   1'b0, -1, -1, 1'b1, -1, 32'h0000A000, 32'h00010000, 1, 1'b1, 34, 1'b0};
    vec[1]  = '{1'b0, 25'h1FFFFFF,   3,   1'b0, -1, -1, 1'b1, -1, 32'h50000000, 32'hFFFFFF80, 4, 1'b1, 37, 1'b0};
    vec[2]  = '{1'b0, 25'h0001234,   0,   1'b1, -1, -1, 1'b1, -1, 32'hC0DE0000, 32'h00091A00, 1, 1'b1, 65, 1'b0};
    vec[3]  = '{1'b0, 25'h0000300,   0,   1'b0, 12, -1, 1'b1, -1, 32'h11110000, 32'h00018000, 1, 1'b0, 0,  1'b0};
    vec[4]  = '{1'b0, 25'h0000301,   0,   1'b0, -1, -1, 1'b1, -1, 32'h22220000, 32'h00018080, 1, 1'b1, 34, 1'b0};
    vec[5]  = '{1'b0, 25'h0000040,   0,   1'b0, 34, -1, 1'b1, -1, 32'h00003300, 32'h00002000, 1, 1'b0, 0,  1'b0};
    vec[6]  = '{1'b0, 25'h0000041,   0,   1'b0, 0,  -1, 1'b1, 10, 32'h44440000, 32'h00002080, 1, 1'b1, 34, 1'b0};
    vec[7]  = '{1'b0, 25'h0000042,   0,   1'b0, -1, -1, 1'b1, 34, 32'h55550000, 32'h00002100, 1, 1'b1, 34, 1'b0};
    vec[8]  = '{1'b0, 25'h0000043,   0,   1'b0, -1, 15, 1'b1, -1, 32'h66660000, 32'h00002180, 1, 1'b1, 34, 1'b1};
    vec[9]  = '{1'b0, 25'h0000044,   0,   1'b0, -1, -1, 1'b1, -1, 32'h77770000, 32'h00002200, 1, 1'b1, 34, 1'b1};
    vec[10] = '{1'b1, 25'h0000045,   0,   1'b0, -1, -1, 1'b0, -1, 32'h88880000, 32'h00002280, 1, 1'b1, 34, 1'b1};
    vec[11] = '{1'b0, 25'h0000046,   0,   1'b0, -1, -1, 1'b1, -1, 32'h99990000, 32'h00002300, 1, 1'b1, 34, 1'b0};

    for (int i = 0; i < 12; i++) begin
      if (i == 11) reset_mid_burst();
      run_vec(i, vec[i]);
    end

    @(posedge CLK); #1;
    idle_inputs();
    @(negedge CLK);
    chk("final busy", 32'(BUSY), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
